// File: rtl/led_effect_scheduler_if.sv
// Request/grant and LED display signals between effect requesters and the scheduler.
interface led_effect_scheduler_if;
  logic       gameover;
  logic       hit_req;
  logic [8:0] hit_pattern;
  logic       score_req;
  logic [8:0] score_pattern;
  logic       hit_grant;
  logic       score_grant;
  logic       busy;
  logic [8:0] ledr;

  modport master (
    output gameover, hit_req, hit_pattern, score_req, score_pattern,
    input  hit_grant, score_grant, busy, ledr
  );

  modport slave (
    input  gameover, hit_req, hit_pattern, score_req, score_pattern,
    output hit_grant, score_grant, busy, ledr
  );
endinterface

// File: rtl/led_effect_scheduler.sv
// LED effect scheduler: arbitrates hit/score flash effects and a game-over animation.
// Define LED_ROUND_ROBIN_EN to arbitrate simultaneous hit/score requests round-robin.
//
// state       | meaning
// ST_IDLE     | LEDs dark, waiting for gameover or a request
// ST_HIT      | flashing the latched hit pattern
// ST_SCORE    | flashing the latched score pattern
// ST_GAMEOVER | cycling the game-over frames while gameover is held
module led_effect_scheduler #(
  parameter int unsigned TICK_DIV   = 3125000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input logic                    clk,
  input logic                    reset,
  led_effect_scheduler_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HIT      = 2'd1;
  localparam logic [1:0] ST_SCORE    = 2'd2;
  localparam logic [1:0] ST_GAMEOVER = 2'd3;

  localparam logic [27:0] TICK_RELOAD = 28'(TICK_DIV - 1);
  localparam logic [3:0]  HOLD_LAST   = 4'(HOLD_TICKS - 1);
  localparam logic [8:0]  GO_FRAME0   = 9'b101010101;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [27:0] tick_cnt;
  logic        tick;
  logic [3:0]  hold_cnt;
  logic        phase;
  logic [8:0]  pattern_q;
  logic [1:0]  frame_idx;
  logic [1:0]  frame_nxt;
  logic        hit_sel;
  logic        score_sel;
  logic        hit_grant_q;
  logic        score_grant_q;
  logic [8:0]  ledr_q;

  function automatic logic [8:0] go_frame(input logic [1:0] idx);
    case (idx)
      2'd0:    go_frame = 9'b101010101;
      2'd1:    go_frame = 9'b100010001;
      2'd2:    go_frame = 9'b100000001;
      default: go_frame = 9'b000000000;
    endcase
  endfunction

  assign tick      = (tick_cnt == 28'd0);
  assign frame_nxt = frame_idx + 2'd1;

`ifdef LED_ROUND_ROBIN_EN
  // prio_hit set means hit wins a tie; flips to the other requester on every grant
  logic prio_hit;

  assign hit_sel = bus.hit_req & (~bus.score_req | prio_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_hit <= 1'b1;
    end else if (state == ST_IDLE && !bus.gameover) begin
      if (hit_sel)
        prio_hit <= 1'b0;
      else if (bus.score_req)
        prio_hit <= 1'b1;
    end
  end
`else
  assign hit_sel = bus.hit_req;
`endif

  assign score_sel = bus.score_req & ~hit_sel;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.gameover)
          state_nxt = ST_GAMEOVER;
        else if (hit_sel)
          state_nxt = ST_HIT;
        else if (score_sel)
          state_nxt = ST_SCORE;
      end
      ST_HIT, ST_SCORE: begin
        if (bus.gameover)
          state_nxt = ST_GAMEOVER;
        else if (tick && hold_cnt == HOLD_LAST)
          state_nxt = ST_IDLE;
      end
      ST_GAMEOVER: begin
        if (!bus.gameover)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= TICK_RELOAD;
      hold_cnt      <= 4'd0;
      phase         <= 1'b0;
      pattern_q     <= 9'd0;
      frame_idx     <= 2'd0;
      hit_grant_q   <= 1'b0;
      score_grant_q <= 1'b0;
      ledr_q        <= 9'd0;
    end else begin
      state         <= state_nxt;
      hit_grant_q   <= 1'b0;
      score_grant_q <= 1'b0;

      // Reload on entry so every state sees a full tick period first
      if (state_nxt != state || tick)
        tick_cnt <= TICK_RELOAD;
      else
        tick_cnt <= tick_cnt - 28'd1;

      case (state)
        ST_IDLE: begin
          if (bus.gameover) begin
            frame_idx <= 2'd0;
            ledr_q    <= GO_FRAME0;
          end else if (hit_sel) begin
            pattern_q   <= bus.hit_pattern;
            ledr_q      <= bus.hit_pattern;
            phase       <= 1'b1;
            hold_cnt    <= 4'd0;
            hit_grant_q <= 1'b1;
          end else if (score_sel) begin
            pattern_q     <= bus.score_pattern;
            ledr_q        <= bus.score_pattern;
            phase         <= 1'b1;
            hold_cnt      <= 4'd0;
            score_grant_q <= 1'b1;
          end else begin
            ledr_q <= 9'd0;
          end
        end
        ST_HIT, ST_SCORE: begin
          if (bus.gameover) begin
            frame_idx <= 2'd0;
            ledr_q    <= GO_FRAME0;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              phase    <= 1'b0;
              hold_cnt <= 4'd0;
              ledr_q   <= 9'd0;
            end else begin
              phase    <= ~phase;
              hold_cnt <= hold_cnt + 4'd1;
              ledr_q   <= phase ? 9'd0 : pattern_q;
            end
          end
        end
        ST_GAMEOVER: begin
          if (!bus.gameover) begin
            ledr_q <= 9'd0;
          end else if (tick) begin
            frame_idx <= frame_nxt;
            ledr_q    <= go_frame(frame_nxt);
          end
        end
        default: ledr_q <= 9'd0;
      endcase
    end
  end

  assign bus.hit_grant   = hit_grant_q;
  assign bus.score_grant = score_grant_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.ledr        = ledr_q;

endmodule

// File: tb/tb_led_effect_scheduler.sv
// Randomized scoreboard bench for led_effect_scheduler with a time-based reference model.
module tb_led_effect_scheduler;
  localparam int TD = 4;
  localparam int HT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  led_effect_scheduler_if bus();

  led_effect_scheduler #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hg;
    logic       sg;
    logic       busy;
    logic [8:0] ledr;
  } obs_t;

  obs_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got hg=%b sg=%b busy=%b ledr=%h, expected hg=%b sg=%b busy=%b ledr=%h",
               name, $time, act.hg, act.sg, act.busy, act.ledr,
               exp.hg, exp.sg, exp.busy, exp.ledr);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.hg   = bus.hit_grant;
    o.sg   = bus.score_grant;
    o.busy = bus.busy;
    o.ledr = bus.ledr;
    return o;
  endfunction

  // Reference model: effect outputs derived from edges elapsed since entering the effect
  localparam int M_IDLE = 0, M_HIT = 1, M_SCORE = 2, M_GO = 3;
  int         m_mode;
  int         m_start;
  int         m_edge;
  logic [8:0] m_pat;
  logic       m_last_hit;
  logic [8:0] frames [4] = '{9'h155, 9'h111, 9'h101, 9'h000};

  always @(posedge clk or negedge reset) begin
    obs_t e;
    int   j;
    logic pick_hit;
    if (!reset) begin
      m_mode     = M_IDLE;
      m_edge     = 0;
      m_start    = 0;
      m_last_hit = 1'b0;
      sb.delete();
    end else begin
      m_edge++;
      e = '0;
      j = (m_edge - m_start) / TD;
      case (m_mode)
        M_IDLE: begin
`ifdef LED_ROUND_ROBIN_EN
          pick_hit = bus.hit_req && (!bus.score_req || !m_last_hit);
`else
          pick_hit = bus.hit_req;
`endif
          if (bus.gameover) begin
            m_mode = M_GO; m_start = m_edge;
          end else if (pick_hit) begin
            m_mode = M_HIT; m_start = m_edge; m_pat = bus.hit_pattern;
            e.hg = 1'b1; m_last_hit = 1'b1;
          end else if (bus.score_req) begin
            m_mode = M_SCORE; m_start = m_edge; m_pat = bus.score_pattern;
            e.sg = 1'b1; m_last_hit = 1'b0;
          end
        end
        M_HIT, M_SCORE: begin
          if (bus.gameover) begin
            m_mode = M_GO; m_start = m_edge;
          end else if (j >= HT) begin
            m_mode = M_IDLE;
          end
        end
        default: begin
          if (!bus.gameover) m_mode = M_IDLE;
        end
      endcase
      j = (m_edge - m_start) / TD;
      e.busy = (m_mode != M_IDLE);
      if (m_mode == M_GO)
        e.ledr = frames[j % 4];
      else if (m_mode == M_HIT || m_mode == M_SCORE)
        e.ledr = (j % 2 == 0) ? m_pat : 9'h000;
      else
        e.ledr = 9'h000;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!reset)
      chk("in_reset", observe(), '0);
    else if (sb.size() > 0)
      chk("cycle", observe(), sb.pop_front());
  end

  int go_left = 0;

  task automatic drive();
    if (bus.hit_req && bus.hit_grant)
      bus.hit_req = 1'b0;
    else if (!bus.hit_req && $urandom_range(0, 3) == 0)
      bus.hit_req = 1'b1;
    if (bus.score_req && bus.score_grant)
      bus.score_req = 1'b0;
    else if (!bus.score_req && $urandom_range(0, 3) == 0)
      bus.score_req = 1'b1;
    bus.hit_pattern   = 9'($urandom);
    bus.score_pattern = 9'($urandom);
    if (go_left == 0) begin
      bus.gameover = ($urandom_range(0, 5) == 0);
      go_left = bus.gameover ? int'($urandom_range(1, 30)) : int'($urandom_range(5, 60));
    end else begin
      go_left--;
    end
  endtask

  task automatic mid_reset();
    int k = 0;
    while (!bus.busy && k < 200) begin
      @(negedge clk);
      drive();
      k++;
    end
    if (!bus.busy) begin
      vectors++;
      errors++;
      $display("FAIL wait_busy: busy=%b after %0d cycles, expected 1", bus.busy, k);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("reset_immediate", observe(), '0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    bus.gameover      = 1'b0;
    bus.hit_req       = 1'b0;
    bus.score_req     = 1'b0;
    bus.hit_pattern   = 9'h000;
    bus.score_pattern = 9'h000;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive();
      if (c == 700 || c == 1500 || c == 2300)
        mid_reset();
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
